ctr_decrypt_stream: RTL and testbench

//   Streaming AES-256 CTR-mode decryptor: the receive side of the CTR encryption path. Accepts 128-bit

---
 rtl/ctr_decrypt_stream.sv | 209 ++++++++++++++++++++
 tb/tb_ctr_decrypt_stream.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_decrypt_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctr_decrypt_stream: AES-256 CTR stream decryptor, one-block keystream     |
// | prefetch via external AES core. CTR_WRAP_ERR_EN adds sticky err output.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ctr_decrypt_stream #(
  parameter int CTR_WIDTH = 32,
  parameter int NB_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    iv,
  input  logic [255:0]    key_i,
  input  logic [NB_W-1:0] num_blocks,
  input  logic            ct_valid,
  output logic            ct_ready,
  input  logic [127:0]    ct_data,
  output logic            pt_valid,
  input  logic            pt_ready,
  output logic [127:0]    pt_data,
  output logic            pt_last,
  output logic            aes_req,
  output logic [127:0]    aes_ctr,
  output logic [255:0]    aes_key,
  input  logic            aes_ack,
  input  logic [127:0]    aes_ks,
  output logic            busy,
  output logic            done
`ifdef CTR_WRAP_ERR_EN
  ,
  output logic            err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [127:0]      ctr_q, ctr_d;
  logic [255:0]      key_q, key_d;
  logic [NB_W-1:0]   gen_cnt_q, gen_cnt_d;
  logic [NB_W-1:0]   out_cnt_q, out_cnt_d;
  logic [127:0]      ks_q, ks_d;
  logic              ks_vld_q, ks_vld_d;
  logic              pt_valid_q, pt_valid_d;
  logic [127:0]      pt_data_q, pt_data_d;
  logic              pt_last_q, pt_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              stall;
  logic [127:0]      ctr_inc;
  logic              aes_fire;
  logic              ct_fire;
  logic              pt_fire;

  // Only the low CTR_WIDTH bits count; the rest is a fixed nonce.
  generate
    if (CTR_WIDTH >= 128) begin : g_ctr_full
      assign ctr_inc = ctr_q + 128'd1;
    end else begin : g_ctr_part
      assign ctr_inc = {ctr_q[127:CTR_WIDTH], ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};
    end
  endgenerate

  assign aes_req  = (state_q == ST_RUN) && !ks_vld_q && (gen_cnt_q != '0);
  assign ct_ready = (state_q == ST_RUN) && ks_vld_q && (!pt_valid_q || pt_ready) && !stall;
  assign aes_fire = aes_req && aes_ack;
  assign ct_fire  = ct_valid && ct_ready;
  assign pt_fire  = pt_valid_q && pt_ready;

  assign aes_ctr  = ctr_q;
  assign aes_key  = key_q;
  assign pt_valid = pt_valid_q;
  assign pt_data  = pt_data_q;
  assign pt_last  = pt_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    key_d      = key_q;
    gen_cnt_d  = gen_cnt_q;
    out_cnt_d  = out_cnt_q;
    ks_d       = ks_q;
    ks_vld_d   = ks_vld_q;
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    pt_last_d  = pt_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_d   = ST_RUN;
            ctr_d     = iv;
            key_d     = key_i;
            gen_cnt_d = num_blocks;
            out_cnt_d = num_blocks;
            ks_vld_d  = 1'b0;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (aes_fire) begin
          ks_d      = aes_ks;
          ks_vld_d  = 1'b1;
          gen_cnt_d = gen_cnt_q - NB_W'(1);
          ctr_d     = ctr_inc;
        end
        if (pt_fire) begin
          pt_valid_d = 1'b0;
          pt_last_d  = 1'b0;
        end
        // A new block may load in the same cycle the previous one drains.
        if (ct_fire) begin
          pt_data_d  = ct_data ^ ks_q;
          pt_valid_d = 1'b1;
          pt_last_d  = (out_cnt_q == NB_W'(1));
          out_cnt_d  = out_cnt_q - NB_W'(1);
          ks_vld_d   = 1'b0;
          if (out_cnt_q == NB_W'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (pt_fire) begin
          pt_valid_d = 1'b0;
          pt_last_d  = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      key_q      <= '0;
      gen_cnt_q  <= '0;
      out_cnt_q  <= '0;
      ks_q       <= '0;
      ks_vld_q   <= 1'b0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      pt_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      key_q      <= key_d;
      gen_cnt_q  <= gen_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ks_q       <= ks_d;
      ks_vld_q   <= ks_vld_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
      pt_last_q  <= pt_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef CTR_WRAP_ERR_EN
  logic err_q, err_d;
  logic wrap_w;

  // Wrapping while more keystream is still owed would reuse counter values.
  assign wrap_w = &ctr_q[CTR_WIDTH-1:0];

  always_comb begin
    err_d = err_q;
    if (aes_fire && wrap_w && (gen_cnt_q > NB_W'(1))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err   = err_q;
  assign stall = err_q;
`else
  assign stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctr_decrypt_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctr_decrypt_stream: scoreboard bench for ctr_decrypt_stream with a     |
// | table-driven AES stand-in on the req/ack port. Rev 1.0                    |
// +--------------------------------------------------------------------------+
module tb_ctr_decrypt_stream;
  localparam logic [255:0] KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] C1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] C2   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
  localparam logic [127:0] C3   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
  localparam logic [127:0] KS0  = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS1  = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] KS2  = 128'h1bc12c9c01610d5d0d8bd6a3378eca62;
  localparam logic [127:0] KS3  = 128'h2956e1c8693536b1bee99c73a31576b6;
  localparam logic [127:0] CT0  = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] CT1  = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] CT2  = 128'h2b0930daa23de94ce87017ba2d84988d;
  localparam logic [127:0] CT3  = 128'hdfc9c58db67aada613c2dd08457941a6;
  localparam logic [127:0] PT0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PT2  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] PT3  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] WIV  = 128'h0123456789abcdef00112233ffffffff;
  localparam logic [127:0] WIV1 = 128'h0123456789abcdef0011223300000000;
  localparam logic [127:0] AIV  = 128'hdeadbeefcafef00d1234567800000010;
  localparam logic [127:0] AIV1 = 128'hdeadbeefcafef00d1234567800000011;
  localparam logic [127:0] BIV  = 128'h11111111222222223333333344444444;
  localparam logic [127:0] RIV  = 128'h55aa55aa00ff00ff0f0f0f0f00000100;
  localparam logic [127:0] XCT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] XCT1 = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] iv;
  logic [255:0] key_i;
  logic [7:0]   num_blocks;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] pt_data;
  logic         pt_last;
  logic         aes_req;
  logic [127:0] aes_ctr;
  logic [255:0] aes_key;
  logic         aes_ack;
  logic [127:0] aes_ks;
  logic         busy;
  logic         done;
`ifdef CTR_WRAP_ERR_EN
  logic         err;
`endif

  ctr_decrypt_stream #(.CTR_WIDTH(32), .NB_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .iv(iv), .key_i(key_i), .num_blocks(num_blocks),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .aes_req(aes_req), .aes_ctr(aes_ctr), .aes_key(aes_key), .aes_ack(aes_ack), .aes_ks(aes_ks),
    .busy(busy), .done(done)
`ifdef CTR_WRAP_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] pt;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] ct_q[$];
  logic [127:0] ctr_log[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, hs_cyc = -1, req_cnt = 0;
  int aes_lat = 1, ack_count = 0, start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Known NIST counters map to their published keystream; others get a fixed scramble.
  function automatic logic [127:0] ks_model(input logic [127:0] c);
    case (c)
      IV:      return KS0;
      C1:      return KS1;
      C2:      return KS2;
      C3:      return KS3;
      default: return {c[95:0], c[127:96]} ^ 128'h5a3c96e1_0f1e2d3c_4b5a6978_8796a5b4;
    endcase
  endfunction

  initial begin : aes_model
    int wait_n;
    wait_n  = 0;
    aes_ack = 1'b0;
    aes_ks  = '0;
    forever begin
      @(negedge clk);
      aes_ack = 1'b0;
      if (aes_req && !rst) begin
        if (wait_n >= aes_lat) begin
          aes_ack = 1'b1;
          aes_ks  = ks_model(aes_ctr);
          ctr_log.push_back(aes_ctr);
          ack_count++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  initial begin : ct_drv
    logic fire;
    ct_valid = 1'b0;
    ct_data  = '0;
    forever begin
      @(negedge clk);
      fire = ct_valid && ct_ready;
      @(posedge clk);
      #1;
      if (fire && ct_q.size() > 0) void'(ct_q.pop_front());
      if (ct_q.size() > 0) begin
        ct_valid = 1'b1;
        ct_data  = ct_q[0];
      end else begin
        ct_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (aes_req) req_cnt++;
      if (pt_valid && pt_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: actual pt_data %h required no output", pt_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_pt_data", pt_data, e.pt);
          check("sb_pt_last", pt_last, e.last);
          if (pt_last) hs_cyc = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [127:0] ct, input logic [127:0] pt, input logic last);
    exp_t e;
    e.pt   = pt;
    e.last = last;
    ct_q.push_back(ct);
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [127:0] v, input logic [255:0] k, input logic [7:0] nb);
    start      = 1'b1;
    iv         = v;
    key_i      = k;
    num_blocks = nb;
    start_cyc  = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, done_cnt, target);
  endtask

  initial begin : stim
    int d0, r0, base, n;
    rst = 1'b1; start = 1'b0; iv = '0; key_i = '0; num_blocks = '0; pt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {ct_ready, pt_valid, pt_last, aes_req, busy, done}, 6'b0);
    check("rst_pt_data", pt_data, 0);
    check("rst_aes_ctr", aes_ctr, 0);
    check("rst_aes_key", aes_key, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // NIST single block
    aes_lat = 2; ctr_log.delete(); d0 = done_cnt;
    enqueue(CT0, PT0, 1'b1);
    do_start(IV, KEY, 8'd1);
    check("n1_busy", busy, 1);
    check("n1_aes_key", aes_key, KEY);
    wait_done(d0 + 1, 200, "n1_done");
    check("n1_done_latency", done_cyc, hs_cyc + 1);
    check("n1_busy_clr", busy, 0);
    check("n1_ctr_cnt", ctr_log.size(), 1);
    check("n1_ctr0", ctr_log[0], IV);
    @(negedge clk);
    check("n1_done_pulse", done, 0);

    // NIST four blocks, streaming
    tick();
    aes_lat = 0; ctr_log.delete(); d0 = done_cnt;
    enqueue(CT0, PT0, 1'b0); enqueue(CT1, PT1, 1'b0);
    enqueue(CT2, PT2, 1'b0); enqueue(CT3, PT3, 1'b1);
    do_start(IV, KEY, 8'd4);
    wait_done(d0 + 1, 300, "n4_done");
    check("n4_ctr_cnt", ctr_log.size(), 4);
    check("n4_ctr0", ctr_log[0], IV);
    check("n4_ctr1", ctr_log[1], C1);
    check("n4_ctr2", ctr_log[2], C2);
    check("n4_ctr3", ctr_log[3], C3);

    // Backpressure: pt_ready low for 10 cycles after first output
    tick();
    pt_ready = 1'b0; aes_lat = 1; ctr_log.delete(); d0 = done_cnt; base = ack_count;
    enqueue(CT0, PT0, 1'b0); enqueue(CT1, PT1, 1'b0);
    enqueue(CT2, PT2, 1'b0); enqueue(CT3, PT3, 1'b1);
    do_start(IV, KEY, 8'd4);
    n = 0;
    while (!pt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_pt_valid", pt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_pt_hold", pt_data, PT0);
      check("bp_ct_ready", ct_ready, 0);
    end
    check("bp_acks", ack_count - base, 2);
    check("bp_no_req", aes_req, 0);
    tick();
    pt_ready = 1'b1;
    wait_done(d0 + 1, 300, "bp_done");

`ifdef CTR_WRAP_ERR_EN
    tick();
    aes_lat = 1; ctr_log.delete(); base = ack_count;
    ct_q.push_back(XCT0); ct_q.push_back(XCT1); ct_q.push_back(XCT0);
    do_start(WIV, KEY2, 8'd3);
    n = 0;
    while (ack_count == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("err_set", err, 1);
    check("err_ct_ready", ct_ready, 0);
    check("err_pt_valid", pt_valid, 0);
    check("err_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    ct_q.delete(); exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("err_clr", err, 0);
`else
    // Counter wrap in the low 32 bits, nonce untouched
    tick();
    aes_lat = 1; ctr_log.delete(); d0 = done_cnt;
    enqueue(XCT0, XCT0 ^ ks_model(WIV), 1'b0);
    enqueue(XCT1, XCT1 ^ ks_model(WIV1), 1'b1);
    do_start(WIV, KEY2, 8'd2);
    wait_done(d0 + 1, 200, "wrap_done");
    check("wrap_ctr0", ctr_log[0], WIV);
    check("wrap_ctr1", ctr_log[1], WIV1);
`endif

    // Zero-length message
    tick();
    d0 = done_cnt; r0 = req_cnt;
    do_start(IV, KEY, 8'd0);
    check("nb0_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("nb0_done_cnt", done_cnt, d0 + 1);
    check("nb0_done_cyc", done_cyc, start_cyc + 1);
    check("nb0_no_req", req_cnt, r0);

    // Start while busy is ignored
    tick();
    aes_lat = 3; ctr_log.delete(); d0 = done_cnt;
    enqueue(XCT0, XCT0 ^ ks_model(AIV), 1'b0);
    enqueue(XCT1, XCT1 ^ ks_model(AIV1), 1'b1);
    do_start(AIV, KEY2, 8'd2);
    do_start(BIV, KEY, 8'd5);
    wait_done(d0 + 1, 300, "sb_done");
    check("sb_ctr_cnt", ctr_log.size(), 2);
    check("sb_ctr0", ctr_log[0], AIV);
    check("sb_ctr1", ctr_log[1], AIV1);
    check("sb_key", aes_key, KEY2);

    // Reset mid-message with a request pending and output held
    tick();
    aes_lat = 1; pt_ready = 1'b0; ctr_log.delete(); base = ack_count;
    ct_q.push_back(XCT0); ct_q.push_back(XCT1); ct_q.push_back(XCT0);
    do_start(RIV, KEY, 8'd3);
    n = 0;
    while (ack_count == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    aes_lat = 100;
    n = 0;
    while (!pt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rm_pre", {aes_req, pt_valid, busy}, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rm_aes_req", aes_req, 0);
    check("rm_pt_valid", pt_valid, 0);
    check("rm_busy", busy, 0);
    ct_q.delete(); exp_q.delete();
    aes_lat = 1; pt_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    ctr_log.delete(); d0 = done_cnt;
    enqueue(XCT1, XCT1 ^ ks_model(AIV), 1'b1);
    do_start(AIV, KEY2, 8'd1);
    wait_done(d0 + 1, 200, "rm_restart_done");
    check("rm_restart_cnt", ctr_log.size(), 1);
    check("rm_restart_ctr", ctr_log[0], AIV);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
